// File: rtl/imem_burst_loader.sv
// imem_burst_loader
//   Avalon-MM burst read master that copies a block of 32-bit words from
//   system memory into the instruction memory write port.
//
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     start               one-cycle copy request (honoured only when idle)
//     src_addr            source byte address (bits [1:0] forced to 0)
//     dst_addr            first imem word address
//     word_count          words to copy, 0..2^ADDR_WIDTH
//     busy, done          status back to the CSR block
//     avm_*               Avalon-MM burst read master
//     mem_*               imem write port (one word per beat)
module imem_burst_loader #(
  parameter int ADDR_WIDTH  = 12,
  parameter int MAX_BURST   = 256,
  parameter int BURST_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [31:0]            src_addr,
  input  logic [ADDR_WIDTH-1:0]  dst_addr,
  input  logic [ADDR_WIDTH:0]    word_count,
  output logic                   busy,
  output logic                   done,
  input  logic                   avm_waitrequest,
  output logic [BURST_WIDTH-1:0] avm_burstcount,
  output logic [31:0]            avm_address,
  output logic                   avm_read,
  input  logic [31:0]            avm_readdata,
  input  logic                   avm_readdatavalid,
  output logic                   mem_write,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_be
);

  typedef enum logic [1:0] {IDLE, REQ, DATA, FIN} state_t;

  state_t                 state_q;
  logic [31:0]            src_q;
  logic [ADDR_WIDTH-1:0]  dst_q;
  logic [ADDR_WIDTH:0]    rem_q;
  logic [BURST_WIDTH-1:0] burst_q;
  logic [BURST_WIDTH-1:0] beats_q;

  logic [31:0]            src_nxt;
  logic [ADDR_WIDTH:0]    rem_nxt;

  function automatic logic [BURST_WIDTH-1:0] burst_len(input logic [ADDR_WIDTH:0] r);
    if (32'(r) > 32'(MAX_BURST)) return BURST_WIDTH'(MAX_BURST);
    else                         return BURST_WIDTH'(r);
  endfunction

  // Pointer/count values after the current burst completes.
  assign src_nxt = src_q + (32'(burst_q) << 2);
  assign rem_nxt = rem_q - (ADDR_WIDTH+1)'(burst_q);

  assign mem_be = {4{mem_write}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      rem_q          <= '0;
      burst_q        <= '0;
      beats_q        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      avm_read       <= 1'b0;
      avm_address    <= '0;
      avm_burstcount <= '0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      mem_write <= 1'b0;
      done      <= 1'b0;
      case (state_q)
        IDLE: begin
          // busy still set here means this is the done cycle; it closes the
          // copy and keeps a start in the same cycle from being honoured.
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            src_q <= src_addr & 32'hFFFF_FFFC;
            dst_q <= dst_addr;
            rem_q <= word_count;
            busy  <= 1'b1;
            if (word_count == '0) begin
              state_q <= FIN;
            end else begin
              state_q        <= REQ;
              avm_read       <= 1'b1;
              avm_address    <= src_addr & 32'hFFFF_FFFC;
              avm_burstcount <= burst_len(word_count);
            end
          end
        end
        REQ: begin
          // Command outputs are registers, so they hold through waitrequest.
          if (!avm_waitrequest) begin
            avm_read       <= 1'b0;
            avm_address    <= '0;
            avm_burstcount <= '0;
            burst_q        <= avm_burstcount;
            beats_q        <= avm_burstcount;
            state_q        <= DATA;
          end
        end
        DATA: begin
          if (avm_readdatavalid) begin
            mem_write <= 1'b1;
            mem_addr  <= dst_q;
            mem_wdata <= avm_readdata;
            dst_q     <= dst_q + ADDR_WIDTH'(1);
            beats_q   <= beats_q - BURST_WIDTH'(1);
            if (beats_q == BURST_WIDTH'(1)) begin
              src_q <= src_nxt;
              rem_q <= rem_nxt;
              if (rem_nxt == '0) begin
                state_q <= FIN;
              end else begin
                // Next command goes out straight after the last beat.
                state_q        <= REQ;
                avm_read       <= 1'b1;
                avm_address    <= src_nxt;
                avm_burstcount <= burst_len(rem_nxt);
              end
            end
          end
        end
        FIN: begin
          // done is registered, so it shows one cycle after FIN is entered:
          // one cycle after the last write, two after a zero-count start.
          done    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
